// File: rtl/fht_but_pipe.sv
// Pipelined 2-point FHT butterfly: y0 = x0 + t, y1 = x0 - t, t = (cos*x1 + sin*x2)/MAX_W,
// with optional rounded 1/2 scaling, saturation/wrap, per-sample flag and sticky overflow.
module fht_but_pipe #(
  parameter int D_BIT  = 16,
  parameter int W_BIT  = 16,
  parameter int EN_SAT = 1
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iEN,
  input  logic                    iVALID,
  input  logic                    iSCALE,
  input  logic signed [D_BIT-1:0] iX_0,
  input  logic signed [D_BIT-1:0] iX_1,
  input  logic signed [D_BIT-1:0] iX_2,
  input  logic signed [W_BIT-1:0] iSIN,
  input  logic signed [W_BIT-1:0] iCOS,
  input  logic                    iCLR_OVF,
  output logic signed [D_BIT-1:0] oY_0,
  output logic signed [D_BIT-1:0] oY_1,
  output logic                    oVALID,
  output logic                    oSAT,
  output logic                    oOVF
);

  localparam int W_FRAC = W_BIT - 2;
  localparam int P_W    = D_BIT + W_BIT;
  localparam int S_W    = P_W + 1;
  localparam int T_W    = D_BIT + 3;
  localparam int A_W    = D_BIT + 4;
  localparam int STAGES = 3;

  localparam logic signed [S_W-1:0] RND  = S_W'(1) <<< (W_FRAC - 1);
  localparam logic signed [A_W-1:0] MAXV = A_W'((2 ** (D_BIT - 1)) - 1);
  localparam logic signed [A_W-1:0] MINV = A_W'(-(2 ** (D_BIT - 1)));

  logic [STAGES:1] vld_pipe;
  logic [2:1]      scl_pipe;

  // stage 1: products
  logic signed [P_W-1:0] p1, p2, p1_q, p2_q;
  logic signed [D_BIT-1:0] x0_s1, x0_s2;

  assign p1 = P_W'(iCOS) * P_W'(iX_1);
  assign p2 = P_W'(iSIN) * P_W'(iX_2);

  // stage 2: sum, round half up, drop fraction bits
  logic signed [S_W-1:0] s_sum, s_rnd;
  logic signed [T_W-1:0] t, t_q;

  assign s_sum = S_W'(p1_q) + S_W'(p2_q);
  assign s_rnd = (s_sum + RND) >>> W_FRAC;
  assign t     = T_W'(s_rnd);

  // stage 3: butterfly, optional halving, range handling
  logic signed [A_W-1:0] a_raw, b_raw, a_sc, b_sc;
  logic                  ovf_a, ovf_b;
  logic signed [D_BIT-1:0] y0, y1;

  assign a_raw = A_W'(x0_s2) + A_W'(t_q);
  assign b_raw = A_W'(x0_s2) - A_W'(t_q);
  assign a_sc  = scl_pipe[2] ? ((a_raw + A_W'(1)) >>> 1) : a_raw;
  assign b_sc  = scl_pipe[2] ? ((b_raw + A_W'(1)) >>> 1) : b_raw;
  assign ovf_a = (a_sc > MAXV) || (a_sc < MINV);
  assign ovf_b = (b_sc > MAXV) || (b_sc < MINV);

  always_comb begin
    y0 = a_sc[D_BIT-1:0];
    y1 = b_sc[D_BIT-1:0];
    if (EN_SAT != 0) begin
      if (ovf_a) y0 = a_sc[A_W-1] ? MINV[D_BIT-1:0] : MAXV[D_BIT-1:0];
      if (ovf_b) y1 = b_sc[A_W-1] ? MINV[D_BIT-1:0] : MAXV[D_BIT-1:0];
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      vld_pipe <= '0;
      scl_pipe <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      x0_s1    <= '0;
      x0_s2    <= '0;
      t_q      <= '0;
      oY_0     <= '0;
      oY_1     <= '0;
      oSAT     <= 1'b0;
    end else if (iEN) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], iVALID};
      scl_pipe <= {scl_pipe[1], iSCALE};
      p1_q     <= p1;
      p2_q     <= p2;
      x0_s1    <= iX_0;
      x0_s2    <= x0_s1;
      t_q      <= t;
      oY_0     <= y0;
      oY_1     <= y1;
      oSAT     <= vld_pipe[2] & (ovf_a | ovf_b);
    end
  end

  assign oVALID = vld_pipe[STAGES];

  // set beats clear so a coincident overflow is never lost; clear ignores iEN
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)                                  oOVF <= 1'b0;
    else if (iEN && vld_pipe[2] && (ovf_a || ovf_b)) oOVF <= 1'b1;
    else if (iCLR_OVF)                           oOVF <= 1'b0;
  end

endmodule

// File: tb/tb_fht_but_pipe.sv
// Directed bench for fht_but_pipe: expected results queued at drive time, checked on output.
module tb_fht_but_pipe;

  logic               iCLK = 1'b0;
  logic               iRESET, iEN, iVALID, iSCALE, iCLR_OVF;
  logic signed [15:0] iX_0, iX_1, iX_2, iSIN, iCOS;
  logic signed [15:0] oY_0, oY_1;
  logic               oVALID, oSAT, oOVF;

  typedef struct {
    real  y0;
    real  y1;
    logic sat;
    real  tol;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   nvalid   = 0;

  always #5 iCLK = ~iCLK;

  fht_but_pipe #(.D_BIT(16), .W_BIT(16), .EN_SAT(1)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iVALID(iVALID), .iSCALE(iSCALE),
    .iX_0(iX_0), .iX_1(iX_1), .iX_2(iX_2), .iSIN(iSIN), .iCOS(iCOS),
    .iCLR_OVF(iCLR_OVF), .oY_0(oY_0), .oY_1(oY_1), .oVALID(oVALID),
    .oSAT(oSAT), .oOVF(oOVF)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input real exp_v, input real tol);
    real d;
    logic ok;
    d  = real'(obs) - exp_v;
    if (d < 0.0) d = -d;
    ok = (d <= tol);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%f tol=%f", tag, obs, exp_v, tol);
    end
  endtask

  // a new result is taken only on an enabled, non-reset edge
  always @(posedge iCLK) begin
    logic en_s;
    exp_t e;
    en_s = iEN;
    #1;
    if (en_s && !iRESET && oVALID) begin
      nvalid++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_valid observed=1 expected=0");
      end else begin
        e = sb.pop_front();
        if (e.tol == 0.0) begin
          chk("y0", int'(oY_0), $rtoi(e.y0));
          chk("y1", int'(oY_1), $rtoi(e.y1));
        end else begin
          chk_tol("y0_ref", int'(oY_0), e.y0, e.tol);
          chk_tol("y1_ref", int'(oY_1), e.y1, e.tol);
        end
        chk("sat", int'(oSAT), int'(e.sat));
      end
    end
  end

  task automatic send(input int x0, input int x1, input int x2, input int c, input int s,
                      input bit sc, input real e0, input real e1, input bit esat, input real tol);
    exp_t e;
    @(negedge iCLK);
    iX_0 = 16'(x0); iX_1 = 16'(x1); iX_2 = 16'(x2);
    iCOS = 16'(c);  iSIN = 16'(s);  iSCALE = sc; iVALID = 1'b1;
    e.y0 = e0; e.y1 = e1; e.sat = esat; e.tol = tol;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge iCLK);
    iVALID = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    idle();
    while (sb.size() > 0 && n < 40) begin
      @(negedge iCLK);
      n++;
    end
    chk({tag, "_drain_left"}, sb.size(), 0);
  endtask

  function automatic real ref_half(input int x0, input int t_num, input bit sc, input bit neg);
    real a;
    a = neg ? real'(x0) - real'(t_num) / 16384.0 : real'(x0) + real'(t_num) / 16384.0;
    return sc ? a / 2.0 : a;
  endfunction

  initial begin
    int base;
    iRESET = 1'b1; iEN = 1'b1; iVALID = 1'b0; iSCALE = 1'b0; iCLR_OVF = 1'b0;
    iX_0 = '0; iX_1 = '0; iX_2 = '0; iSIN = '0; iCOS = '0;
    #12;
    chk("rst_y0", int'(oY_0), 0);
    chk("rst_y1", int'(oY_1), 0);
    chk("rst_valid", int'(oVALID), 0);
    chk("rst_sat", int'(oSAT), 0);
    chk("rst_ovf", int'(oOVF), 0);
    @(negedge iCLK);
    iRESET = 1'b0;

    // 0 deg and 45 deg rounding, scaled
    send(1000, 2000, 0, 16384, 0, 1'b1, 1500.0, -500.0, 1'b0, 0.0);
    send(0, 10000, 10000, 11585, 11585, 1'b1, 7071.0, -7071.0, 1'b0, 0.0);
    drain("rot");
    chk("ovf_clean", int'(oOVF), 0);

    // saturation makes the overflow sticky
    send(30000, 10000, 0, 16384, 0, 1'b0, 32767.0, 20000.0, 1'b1, 0.0);
    drain("sat");
    chk("ovf_set", int'(oOVF), 1);
    repeat (3) @(negedge iCLK);
    chk("ovf_sticky", int'(oOVF), 1);
    @(negedge iCLK); iCLR_OVF = 1'b1;
    @(negedge iCLK); iCLR_OVF = 1'b0;
    chk("ovf_cleared", int'(oOVF), 0);

    // extreme coefficient; unscaled version collides with a clear
    send(0, -32768, 0, -16384, 0, 1'b1, 16384.0, -16384.0, 1'b0, 0.0);
    drain("ext_sc");
    chk("ovf_ext_sc", int'(oOVF), 0);
    send(0, -32768, 0, -16384, 0, 1'b0, 32767.0, -32768.0, 1'b1, 0.0);
    idle();
    @(negedge iCLK); iCLR_OVF = 1'b1;
    @(negedge iCLK); iCLR_OVF = 1'b0;
    chk("ovf_set_wins", int'(oOVF), 1);
    drain("ext");

    // burst of 8 with a 2-cycle stall holding sample 4
    base = nvalid;
    for (int i = 0; i < 8; i++) begin
      int x0, x1, x2, c, s;
      bit sc;
      x0 = int'($urandom_range(16000)) - 8000;
      x1 = int'($urandom_range(16000)) - 8000;
      x2 = int'($urandom_range(16000)) - 8000;
      c  = int'($urandom_range(23170)) - 11585;
      s  = int'($urandom_range(23170)) - 11585;
      sc = i[0];
      send(x0, x1, x2, c, s, sc, ref_half(x0, c * x1 + s * x2, sc, 1'b0),
           ref_half(x0, c * x1 + s * x2, sc, 1'b1), 1'b0, 1.0);
      if (i == 4) begin
        iEN = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        iEN = 1'b1;
      end
    end
    drain("stream");
    chk("stream_pulses", nvalid - base, 8);

    // async reset with 2 samples in flight; oOVF is still set from the collision
    send(100, 200, 0, 16384, 0, 1'b0, 300.0, -100.0, 1'b0, 0.0);
    send(30000, 10000, 0, 16384, 0, 1'b0, 32767.0, 20000.0, 1'b1, 0.0);
    @(posedge iCLK);
    #2;
    iRESET = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_y0", int'(oY_0), 0);
    chk("mid_rst_y1", int'(oY_1), 0);
    chk("mid_rst_valid", int'(oVALID), 0);
    chk("mid_rst_sat", int'(oSAT), 0);
    chk("mid_rst_ovf", int'(oOVF), 0);
    base = nvalid;
    @(negedge iCLK); iVALID = 1'b0;
    @(negedge iCLK); iRESET = 1'b0;
    repeat (6) @(negedge iCLK);
    chk("post_rst_pulses", nvalid - base, 0);
    chk("post_rst_ovf", int'(oOVF), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
